// File: rtl/deser_rr_sched_if.sv
// rtl/deser_rr_sched_if.sv - requester, deserializer and consumer signals of the shared deserializer scheduler
interface deser_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_data;
  logic [N_REQ-1:0] req_ready;
  logic             des_data_in;
  logic             des_write_in;
  logic             des_ack_in;
  logic [7:0]       des_data_out;
  logic             des_data_ready;
  logic             des_status_out;
  logic [7:0]       byte_out;
  logic [ID_W-1:0]  byte_src;
  logic             byte_valid;
  logic             byte_ready;
  logic             busy;
  logic [ID_W-1:0]  grant_id;

  modport master (
    input  req_valid, req_data, des_data_out, des_data_ready, des_status_out, byte_ready,
    output req_ready, des_data_in, des_write_in, des_ack_in,
           byte_out, byte_src, byte_valid, busy, grant_id
  );

  modport slave (
    output req_valid, req_data, des_data_out, des_data_ready, des_status_out, byte_ready,
    input  req_ready, des_data_in, des_write_in, des_ack_in,
           byte_out, byte_src, byte_valid, busy, grant_id
  );
endinterface

// File: rtl/deser_rr_sched.sv
// rtl/deser_rr_sched.sv - round-robin grant of one 8-bit deserializer to N_REQ serial requesters
module deser_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic              clk_100khz,
  input logic              reset_n,
  deser_rr_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RDY, RELEASE} state_t;

  localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);
  localparam logic [ID_W:0] ONE_W   = (ID_W+1)'(1);

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   grant_q, grant_nxt;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]  req_rot, rot_scan;
  logic [ID_W-1:0]   offset, winner, winner_inc;
  logic [ID_W:0]     win_sum, inc_sum;
  logic              found;
  logic              accept, load, ack, des_bit;
  logic [N_REQ-1:0]  req_ready_c;
  logic [7:0]        byte_q;
  logic [ID_W-1:0]   src_q;
  logic              valid_q;

  // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
  assign req_dbl = {bus.req_valid, bus.req_valid} >> rr_ptr;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    found    = 1'b0;
    offset   = '0;
    rot_scan = req_rot;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot_scan[0]) begin
        found  = 1'b1;
        offset = ID_W'(k);
      end
      rot_scan = rot_scan >> 1;
    end
  end

  assign win_sum    = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner     = (win_sum >= N_REQ_W) ? ID_W'(win_sum - N_REQ_W) : win_sum[ID_W-1:0];
  assign inc_sum    = {1'b0, winner} + ONE_W;
  assign winner_inc = (inc_sum == N_REQ_W) ? '0 : inc_sum[ID_W-1:0];

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    rr_ptr_nxt  = rr_ptr;
    grant_nxt   = grant_q;
    accept      = 1'b0;
    load        = 1'b0;
    ack         = 1'b0;
    des_bit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt   = winner;
          rr_ptr_nxt  = winner_inc;
          bit_cnt_nxt = 3'd0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // A dropped req_valid simply stalls here; the grant is held for the whole byte.
        des_bit = bus.req_data[grant_q];
        accept  = bus.req_valid[grant_q] & bus.des_status_out & ~bus.des_data_ready;
        if (accept) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.des_data_ready && (!valid_q || bus.byte_ready)) begin
          load      = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_c          = '0;
    req_ready_c[grant_q] = accept;
  end

  always_ff @(posedge clk_100khz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      rr_ptr  <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
      grant_q <= grant_nxt;
    end
  end

  // Output slot: a reload in the same cycle as a consume keeps byte_valid high.
  always_ff @(posedge clk_100khz or negedge reset_n) begin
    if (!reset_n) begin
      byte_q  <= 8'h00;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      byte_q  <= bus.des_data_out;
      src_q   <= grant_q;
      valid_q <= 1'b1;
    end else if (bus.byte_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.des_data_in  = des_bit;
  assign bus.des_write_in = accept;
  assign bus.des_ack_in   = ack;
  assign bus.byte_out     = byte_q;
  assign bus.byte_src     = src_q;
  assign bus.byte_valid   = valid_q;
  assign bus.busy         = (state != IDLE);
  assign bus.grant_id     = grant_q;
endmodule

// File: tb/tb_deser_rr_sched.sv
// tb/tb_deser_rr_sched.sv - scheduler bench with a behavioural deserializer and an output scoreboard
module tb_deser_rr_sched;
  logic clk_100khz;
  logic reset_n;

  deser_rr_sched_if #(.N_REQ(4), .ID_W(2)) bus ();

  deser_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk_100khz (clk_100khz),
    .reset_n    (reset_n),
    .bus        (bus.master)
  );

  initial clk_100khz = 1'b0;
  always #5 clk_100khz = ~clk_100khz;

  // Deserializer model sharing the scheduler's reset.
  logic [7:0] d_sh;
  logic [3:0] d_cnt;
  logic       d_full;

  always @(posedge clk_100khz or negedge reset_n) begin
    if (!reset_n) begin
      d_sh <= 8'h00; d_cnt <= 4'd0; d_full <= 1'b0;
    end else if (bus.des_ack_in && d_full) begin
      d_sh <= 8'h00; d_cnt <= 4'd0; d_full <= 1'b0;
    end else if (bus.des_write_in && !d_full) begin
      d_sh <= {d_sh[6:0], bus.des_data_in};
      if (d_cnt == 4'd7) begin d_full <= 1'b1; d_cnt <= 4'd0; end
      else d_cnt <= d_cnt + 4'd1;
    end
  end

  assign bus.des_status_out = ~d_full;
  assign bus.des_data_ready = d_full;
  assign bus.des_data_out   = d_sh;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rq_byte [4][4];
  int         rq_n [4];
  int         rq_idx [4];
  int         bitpos [4];
  logic [3:0] en;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  logic [3:0] s_rdy;
  logic       s_write, s_ack, s_din, s_busy, s_bv, s_brdy;
  logic [7:0] s_bo;
  logic [1:0] s_bs, s_grant;

  task automatic drive();
    logic [3:0] v, d;
    logic [7:0] b;
    v = '0; d = '0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && rq_idx[i] < rq_n[i]) begin
        v[i] = 1'b1;
        b = rq_byte[i][rq_idx[i]] << bitpos[i];
        d[i] = b[7];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      rq_n[i] = 0; rq_idx[i] = 0; bitpos[i] = 0;
    end
    en = 4'b1111;
    exp_q.delete();
    drive();
  endtask

  // Sample one cycle at the falling edge, then present the next requester bits after the rising edge.
  task automatic tick();
    @(negedge clk_100khz);
    s_rdy = bus.req_ready;   s_write = bus.des_write_in; s_ack = bus.des_ack_in;
    s_din = bus.des_data_in; s_busy = bus.busy;          s_bv = bus.byte_valid;
    s_brdy = bus.byte_ready; s_bo = bus.byte_out;        s_bs = bus.byte_src;
    s_grant = bus.grant_id;
    for (int i = 0; i < 4; i++) begin
      if (s_rdy[i]) begin
        bitpos[i]++;
        if (bitpos[i] == 8) begin bitpos[i] = 0; rq_idx[i]++; end
      end
    end
    @(posedge clk_100khz);
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.byte_ready = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk_100khz);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.byte_ready = 1'b1;
    clear_reqs();
    rq_byte[1][0] = 8'hFF; rq_n[1] = 1;
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({s_rdy, s_write, s_ack, s_din, s_busy, s_bv, s_bo, s_bs, s_grant} !== 24'h0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc %0d rdy=%b wr=%b ack=%b busy=%b bv=%b bo=%h bs=%0d gid=%0d, want all 0",
                 k, s_rdy, s_write, s_ack, s_busy, s_bv, s_bo, s_bs, s_grant);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    rq_byte[2][0] = 8'hA5; rq_n[2] = 1;
    exp_q.push_back({2'd2, 8'hA5});
    drive();
    for (int k = 0; k < 14; k++) begin
      tick();
      vectors++;
      if (s_rdy !== ((k >= 1 && k <= 8) ? 4'b0100 : 4'b0000)) begin
        miscompares++; $display("FAIL single_req_ready cyc %0d got %b", k, s_rdy);
      end
      vectors++;
      if (s_ack !== (k == 10) || s_bv !== (k == 10)) begin
        miscompares++; $display("FAIL single_ack_valid cyc %0d ack=%b bv=%b, want %b", k, s_ack, s_bv, (k == 10));
      end
      if (s_bv && s_brdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL single_sb extra src=%0d byte=%h", s_bs, s_bo);
        end else begin
          e = exp_q.pop_front();
          if ({s_bs, s_bo} !== e) begin
            miscompares++; $display("FAIL single_sb got src=%0d byte=%h want src=%0d byte=%h", s_bs, s_bo, e[9:8], e[7:0]);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_pending left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int last_rise;
    logic prev_bv;
    do_reset();
    rq_byte[0][0] = 8'h11; rq_byte[0][1] = 8'h15; rq_n[0] = 2;
    rq_byte[1][0] = 8'h22; rq_n[1] = 1;
    rq_byte[2][0] = 8'h33; rq_n[2] = 1;
    rq_byte[3][0] = 8'h44; rq_n[3] = 1;
    exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd2, 8'h33}); exp_q.push_back({2'd3, 8'h44});
    exp_q.push_back({2'd0, 8'h15});
    drive();
    last_rise = -1; prev_bv = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (s_bv && !prev_bv) begin
        vectors++;
        if (last_rise < 0 && k != 10) begin
          miscompares++; $display("FAIL rr_first_rise got cyc %0d want 10", k);
        end else if (last_rise >= 0 && k - last_rise != 11) begin
          miscompares++; $display("FAIL rr_spacing got %0d want 11", k - last_rise);
        end
        last_rise = k;
      end
      prev_bv = s_bv;
      if (s_bv && s_brdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rr_sb extra src=%0d byte=%h", s_bs, s_bo);
        end else begin
          e = exp_q.pop_front();
          if ({s_bs, s_bo} !== e) begin
            miscompares++; $display("FAIL rr_sb got src=%0d byte=%h want src=%0d byte=%h", s_bs, s_bo, e[9:8], e[7:0]);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr_pending left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int pops;
    do_reset();
    rq_byte[1][0] = 8'h6C; rq_n[1] = 1;
    rq_byte[0][0] = 8'h93; rq_n[0] = 1;
    en = 4'b1110;
    exp_q.push_back({2'd1, 8'h6C}); exp_q.push_back({2'd0, 8'h93});
    drive();
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k >= 4 && k <= 8) begin
        vectors++;
        if (s_rdy !== 4'b0000) begin miscompares++; $display("FAIL stall_req_ready cyc %0d got %b want 0000", k, s_rdy); end
      end
      if (k == 3) begin en[1] = 1'b0; en[0] = 1'b1; drive(); end
      if (k == 8) begin en[1] = 1'b1; drive(); end
      if (s_bv && s_brdy) begin
        pops++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL stall_sb extra src=%0d byte=%h", s_bs, s_bo);
        end else begin
          e = exp_q.pop_front();
          if ({s_bs, s_bo} !== e) begin
            miscompares++; $display("FAIL stall_sb got src=%0d byte=%h want src=%0d byte=%h", s_bs, s_bo, e[9:8], e[7:0]);
          end
        end
        if (pops == 1) begin
          vectors++;
          if (k != 15) begin miscompares++; $display("FAIL stall_latency got cyc %0d want 15", k); end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_pending left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rq_byte[0][0] = 8'hC3; rq_n[0] = 1;
    rq_byte[1][0] = 8'h3C; rq_n[1] = 1;
    exp_q.push_back({2'd0, 8'hC3}); exp_q.push_back({2'd1, 8'h3C});
    drive();
    for (int k = 0; k < 46; k++) begin
      bus.byte_ready = (k >= 40);
      tick();
      if (k >= 20 && k <= 39) begin
        vectors++;
        if ({s_busy, s_ack, s_bv, s_rdy, s_bs, s_bo} !== {1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 8'hC3}) begin
          miscompares++;
          $display("FAIL bp_hold cyc %0d busy=%b ack=%b bv=%b rdy=%b bs=%0d bo=%h want 1 0 1 0000 0 c3",
                   k, s_busy, s_ack, s_bv, s_rdy, s_bs, s_bo);
        end
      end
      if (k == 41) begin
        vectors++;
        if ({s_ack, s_bv, s_bo} !== {1'b1, 1'b1, 8'h3C}) begin
          miscompares++; $display("FAIL bp_release ack=%b bv=%b bo=%h want 1 1 3c", s_ack, s_bv, s_bo);
        end
      end
      if (s_bv && s_brdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_sb extra src=%0d byte=%h", s_bs, s_bo);
        end else begin
          e = exp_q.pop_front();
          if ({s_bs, s_bo} !== e) begin
            miscompares++; $display("FAIL bp_sb got src=%0d byte=%h want src=%0d byte=%h", s_bs, s_bo, e[9:8], e[7:0]);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_pending left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rq_byte[0][0] = 8'hF0; rq_n[0] = 1;
    drive();
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (bus.des_write_in !== 1'b1) begin miscompares++; $display("FAIL mid_pre_write got %b want 1", bus.des_write_in); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.req_ready, bus.des_write_in, bus.des_ack_in, bus.des_data_in, bus.busy,
         bus.byte_valid, bus.byte_out, bus.byte_src, bus.grant_id} !== 24'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs rdy=%b wr=%b ack=%b busy=%b bv=%b bo=%h gid=%0d want all 0",
               bus.req_ready, bus.des_write_in, bus.des_ack_in, bus.busy, bus.byte_valid, bus.byte_out, bus.grant_id);
    end
    clear_reqs();
    repeat (2) @(posedge clk_100khz);
    #1;
    reset_n = 1'b1;
    rq_byte[3][0] = 8'h0F; rq_n[3] = 1;
    exp_q.push_back({2'd3, 8'h0F});
    drive();
    for (int k = 0; k < 14; k++) begin
      tick();
      if (s_bv && s_brdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL mid_sb extra src=%0d byte=%h", s_bs, s_bo);
        end else begin
          e = exp_q.pop_front();
          if ({s_bs, s_bo} !== e || k != 10) begin
            miscompares++; $display("FAIL mid_sb cyc %0d got src=%0d byte=%h want cyc 10 src=%0d byte=%h", k, s_bs, s_bo, e[9:8], e[7:0]);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL mid_pending left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_only_req3();
    do_reset();
    rq_byte[3][0] = 8'h81; rq_byte[3][1] = 8'h42; rq_byte[3][2] = 8'h24; rq_n[3] = 3;
    exp_q.push_back({2'd3, 8'h81}); exp_q.push_back({2'd3, 8'h42}); exp_q.push_back({2'd3, 8'h24});
    drive();
    for (int k = 0; k < 40; k++) begin
      tick();
      vectors++;
      if ((s_rdy & 4'b0111) !== 4'b0000) begin miscompares++; $display("FAIL r3_other_ready cyc %0d got %b", k, s_rdy); end
      if (k == 1 || k == 12) begin
        vectors++;
        if ({s_grant, dut.rr_ptr} !== {2'd3, 2'd0}) begin
          miscompares++; $display("FAIL r3_grant_ptr cyc %0d gid=%0d ptr=%0d want 3 0", k, s_grant, dut.rr_ptr);
        end
      end
      if (s_bv && s_brdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL r3_sb extra src=%0d byte=%h", s_bs, s_bo);
        end else begin
          e = exp_q.pop_front();
          if ({s_bs, s_bo} !== e) begin
            miscompares++; $display("FAIL r3_sb got src=%0d byte=%h want src=%0d byte=%h", s_bs, s_bo, e[9:8], e[7:0]);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL r3_pending left=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.byte_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_only_req3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/deser_rr_sched.md
# deser_rr_sched

Round-robin scheduler that shares one 8-bit serial-to-parallel deserializer among `N_REQ` serial requesters in the 100 kHz domain. It grants one requester for exactly one byte (8 accepted bits) and gates that requester's bits into the deserializer. When the byte is complete it captures the byte, tags it with the source index, acknowledges the deserializer, and presents the tagged byte to a downstream consumer through a valid/ready handshake.

## Interface
- `N_REQ`, default 4: number of serial requesters, 2..8.
- `ID_W`, default 2: width of the source tag; must equal ceil(log2(`N_REQ`)).

- `clk_100khz`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`  requester i has a serial bit on `req_data[i]`.
- `req_data`  in  `N_REQ`  serial bit per requester, MSB of the byte first.
- `req_ready`  out  `N_REQ`  one-hot or zero; bit i of requester i was accepted this cycle.
- `des_data_in`  out  1  serial bit to the deserializer.
- `des_write_in`  out  1  bit-valid strobe to the deserializer.
- `des_ack_in`  out  1  consume acknowledge to the deserializer.
- `des_data_out`  in  8  parallel byte from the deserializer.
- `des_data_ready`  in  1  deserializer holds a complete byte.
- `des_status_out`  in  1  deserializer can accept bits (1 = available).
- `byte_out`  out  8  captured byte.
- `byte_src`  out  `ID_W`  index of the requester that supplied `byte_out`.
- `byte_valid`  out  1  `byte_out`/`byte_src` are valid.
- `byte_ready`  in  1  consumer accepts the byte.
- `busy`  out  1  1 in any state other than IDLE.
- `grant_id`  out  `ID_W`  currently or most recently granted requester.

## Operation
- Deserializer contract:
  - A bit is taken on each edge where `des_write_in`=1, `des_status_out`=1 and `des_data_ready`=0.
  - After the 8th bit, `des_data_ready`=1 and `des_status_out`=0 from the next cycle.
  - `des_ack_in` sampled high while `des_data_ready`=1 clears `des_data_ready`, restores `des_status_out`=1 and clears the deserializer's byte on the next edge.
- FSM states: IDLE, SHIFT, WAIT_RDY, RELEASE.
- IDLE:
  - If any `req_valid`=1, pick the first set bit searching from `rr_ptr` upward with wrap.
  - Register `grant_id` = winner, set `rr_ptr` = (winner+1) mod `N_REQ`, clear `bit_cnt`, go to SHIFT.
  - With no requests, stay in IDLE.
- SHIFT:
  - `des_write_in` = `req_valid[grant_id]` & `des_status_out` & ~`des_data_ready`.
  - `des_data_in` = `req_data[grant_id]`.
  - `req_ready[grant_id]` = `des_write_in`; all other `req_ready` bits = 0.
  - Each accepted bit increments `bit_cnt` (3 bits).
  - The accept at `bit_cnt`=7 goes to WAIT_RDY.
  - If the granted requester drops `req_valid` mid-byte, hold the grant and stall. No other requester is served until 8 bits are accepted.
- WAIT_RDY:
  - When `des_data_ready`=1 and the output slot is free (`byte_valid`=0, or `byte_ready`=1 this cycle), latch `byte_out` = `des_data_out`, `byte_src` = `grant_id`, set `byte_valid`=1, go to RELEASE.
  - Otherwise stay in WAIT_RDY (back-pressure holds the byte in the deserializer).
- RELEASE:
  - `des_ack_in`=1 for exactly this one cycle; go to IDLE.
- Output slot:
  - `byte_valid` clears on `byte_ready`=1 unless reloaded the same cycle.
  - `byte_out`/`byte_src` are stable while `byte_valid`=1 and `byte_ready`=0.
- `des_ack_in`, `des_write_in` and `req_ready` are 0 outside their states above.
- Reset (asynchronous, any state, including mid-byte):
  - State = IDLE, `bit_cnt`=0, `rr_ptr`=0, `grant_id`=0.
  - `byte_out`=0x00, `byte_src`=0, `byte_valid`=0, `busy`=0.
  - All `req_ready` and `des_*` outputs = 0.
  - A partial byte is discarded; the deserializer is reset by the same `reset_n`.

## Timing
- Request seen in IDLE at cycle 0: SHIFT from cycle 1. With continuous `req_valid`, bits are accepted in cycles 1–8.
- WAIT_RDY is cycle 9, where `des_data_ready` is first seen; the byte is latched at the end of cycle 9.
- `byte_valid`=1 and `des_ack_in`=1 in cycle 10; IDLE in cycle 11; the next grant's first bit is accepted in cycle 12.
- Best-case throughput: one byte per 11 cycles.
- Stalls extend SHIFT by one cycle per cycle without an accept. Back-pressure extends WAIT_RDY one cycle per stalled cycle.
- Grant arbitration is registered: a request arriving in cycle k while in IDLE is first served (`req_ready`) in cycle k+1.

## Test plan
- Reset, then requester 2 sends 0xA5 continuously: `req_ready[2]` is high in cycles 1–8; `byte_out`=0xA5, `byte_src`=2 and `byte_valid` are high in cycle 10; `des_ack_in` is a single-cycle pulse in cycle 10.
- All 4 requesters valid, sending 0x11/0x22/0x33/0x44, consumer always ready: output order is src 0,1,2,3,0 with matching bytes; consecutive `byte_valid` rises are 11 cycles apart.
- Requester 1 drops `req_valid` for 5 cycles after bit 3 while requester 0 stays valid: no `req_ready[0]` during the stall; requester 1's byte completes correctly 5 cycles late with `byte_src`=1.
- `byte_ready`=0 for 20 cycles with one byte pending and a second complete in the deserializer: FSM holds in WAIT_RDY, no `des_ack_in`, `byte_out` is stable; the second byte is latched in the cycle `byte_ready` returns to 1.
- `reset_n` low after 4 bits of 0xF0: all outputs go to 0 immediately. After release with requester 3 sending 0x0F, `byte_out`=0x0F and `byte_src`=3, with no residue of the partial byte.
- Only requester 3 requests repeatedly: each grant goes to 3, `rr_ptr` wraps to 0, and no `req_ready` pulses appear on other bits.
